// File: rtl/cirno9_sram_arb_pkg.sv
// -----------------------------------------------------------------------------
// cirno9_sram_arb_pkg
// Shared types and constants for the two-master SRAM arbiter.
//   state_e     : arbiter FSM state (IDLE, RESP)
//   M_CORE/M_DBG: master indices used for owner / round-robin tracking
//   wait_cnt_w(): width of a saturating wait counter that must hold MAX_WAIT
// -----------------------------------------------------------------------------
package cirno9_sram_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    localparam logic M_CORE = 1'b0;
    localparam logic M_DBG  = 1'b1;

    function automatic int wait_cnt_w(input int max_wait);
        return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/cirno9_rr_pick2.sv
// -----------------------------------------------------------------------------
// cirno9_rr_pick2
// Combinational two-way winner select for the SRAM arbiter.
//   val0_i/val1_i     : request valid of core (0) and debug (1) master
//   rr_last_i         : index of the master that won the previous grant
//   starve0_i/1_i     : wait counter of that master has reached its limit
//   halt_i            : debug halt, only the debug master may win
//   gnt_o             : some master wins this cycle
//   win_o             : index of the winning master (valid with gnt_o)
// -----------------------------------------------------------------------------
module cirno9_rr_pick2
    import cirno9_sram_arb_pkg::*;
(
    input  logic val0_i,
    input  logic val1_i,
    input  logic rr_last_i,
    input  logic starve0_i,
    input  logic starve1_i,
    input  logic halt_i,
    output logic gnt_o,
    output logic win_o
);

    always_comb begin
        gnt_o = 1'b0;
        win_o = M_CORE;
        if (halt_i) begin
            gnt_o = val1_i;
            win_o = M_DBG;
        end else if (val0_i && val1_i) begin
            gnt_o = 1'b1;
            // Starvation overrides round robin; both cannot be starving at
            // once because every contested grant clears the winner's count.
            if (starve0_i) begin
                win_o = M_CORE;
            end else if (starve1_i) begin
                win_o = M_DBG;
            end else begin
                win_o = ~rr_last_i;
            end
        end else if (val0_i) begin
            gnt_o = 1'b1;
            win_o = M_CORE;
        end else if (val1_i) begin
            gnt_o = 1'b1;
            win_o = M_DBG;
        end
    end

endmodule

// File: rtl/cirno9_sram_arb.sv
// -----------------------------------------------------------------------------
// cirno9_sram_arb
// Arbitrates the single-port sram32 macro between the core load/store port
// (m0) and the JTAG debug memory port (m1). Each access is a grant cycle
// (IDLE) followed by a response cycle (RESP) covering the SRAM read latency.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | arbitrate; on a winner drive the SRAM access this cycle
//   RESP  | SRAM data valid; pulse owner's rdy with sram_dout, no grant
//
// Ports:
//   clk, rst_n                : clock, async active-low reset
//   i_halt                    : debug halt, only m1 is granted while high
//   mX_val/adr/wen/wdat       : master request (wen==0 is a read)
//   mX_rdy/rdat               : one-cycle completion pulse and read data
//   sram_en/we/adr/din        : SRAM request side
//   sram_dout                 : SRAM read data, one cycle after sram_en
// -----------------------------------------------------------------------------
module cirno9_sram_arb
    import cirno9_sram_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_halt,

    input  logic                m0_val,
    output logic                m0_rdy,
    input  logic [ADDR_W-1:0]   m0_adr,
    input  logic [DATA_W/8-1:0] m0_wen,
    input  logic [DATA_W-1:0]   m0_wdat,
    output logic [DATA_W-1:0]   m0_rdat,

    input  logic                m1_val,
    output logic                m1_rdy,
    input  logic [ADDR_W-1:0]   m1_adr,
    input  logic [DATA_W/8-1:0] m1_wen,
    input  logic [DATA_W-1:0]   m1_wdat,
    output logic [DATA_W-1:0]   m1_rdat,

    output logic                sram_en,
    output logic [DATA_W/8-1:0] sram_we,
    output logic [ADDR_W-1:0]   sram_adr,
    output logic [DATA_W-1:0]   sram_din,
    input  logic [DATA_W-1:0]   sram_dout
);

    localparam int                BE_W    = DATA_W / 8;
    localparam int                CNT_W   = wait_cnt_w(MAX_WAIT);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_WAIT);

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                rr_last_q, rr_last_d;
    logic [CNT_W-1:0]    wait0_q, wait0_d;
    logic [CNT_W-1:0]    wait1_q, wait1_d;
    logic [ADDR_W-1:0]   adr_q;
    logic [DATA_W-1:0]   din_q;

    logic                pick_gnt;
    logic                pick_win;
    logic                grant;
    logic                contend;
    logic [ADDR_W-1:0]   win_adr;
    logic [BE_W-1:0]     win_wen;
    logic [DATA_W-1:0]   win_wdat;

    cirno9_rr_pick2 u_pick (
        .val0_i    (m0_val),
        .val1_i    (m1_val),
        .rr_last_i (rr_last_q),
        .starve0_i (wait0_q == CNT_MAX),
        .starve1_i (wait1_q == CNT_MAX),
        .halt_i    (i_halt),
        .gnt_o     (pick_gnt),
        .win_o     (pick_win)
    );

    assign grant    = (state_q == IDLE) && pick_gnt;
    // Only a master that was a real candidate counts a loss; m0 held off by
    // halt is not losing arbitration.
    assign contend  = m0_val && m1_val && !i_halt;
    assign win_adr  = (pick_win == M_DBG) ? m1_adr  : m0_adr;
    assign win_wen  = (pick_win == M_DBG) ? m1_wen  : m0_wen;
    assign win_wdat = (pick_win == M_DBG) ? m1_wdat : m0_wdat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= M_CORE;
            rr_last_q <= M_DBG;
            wait0_q   <= '0;
            wait1_q   <= '0;
            adr_q     <= '0;
            din_q     <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            wait0_q   <= wait0_d;
            wait1_q   <= wait1_d;
            adr_q     <= sram_adr;
            din_q     <= sram_din;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        wait0_d   = wait0_q;
        wait1_d   = wait1_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d   = RESP;
                    owner_d   = pick_win;
                    rr_last_d = pick_win;
                    if (pick_win == M_CORE) begin
                        wait0_d = '0;
                        if (contend && (wait1_q != CNT_MAX)) begin
                            wait1_d = wait1_q + 1'b1;
                        end
                    end else begin
                        wait1_d = '0;
                        if (contend && (wait0_q != CNT_MAX)) begin
                            wait0_d = wait0_q + 1'b1;
                        end
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sram_en  = 1'b0;
        sram_we  = '0;
        sram_adr = adr_q;
        sram_din = din_q;
        m0_rdy   = 1'b0;
        m1_rdy   = 1'b0;
        m0_rdat  = '0;
        m1_rdat  = '0;
        case (state_q)
            IDLE: begin
                if (pick_gnt) begin
                    sram_en  = 1'b1;
                    sram_we  = win_wen;
                    sram_adr = win_adr;
                    sram_din = win_wdat;
                end
            end
            RESP: begin
                if (owner_q == M_CORE) begin
                    m0_rdy  = 1'b1;
                    m0_rdat = sram_dout;
                end else begin
                    m1_rdy  = 1'b1;
                    m1_rdat = sram_dout;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cirno9_sram_arb.sv
module tb_cirno9_sram_arb;
    import cirno9_sram_arb_pkg::*;

    localparam int MAXW = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_halt;
    logic        m0_val, m0_rdy, m1_val, m1_rdy;
    logic [31:0] m0_adr, m0_wdat, m0_rdat, m1_adr, m1_wdat, m1_rdat;
    logic [3:0]  m0_wen, m1_wen;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_adr, sram_din, sram_dout;

    cirno9_sram_arb #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst_n(rst_n), .i_halt(i_halt),
        .m0_val(m0_val), .m0_rdy(m0_rdy), .m0_adr(m0_adr), .m0_wen(m0_wen),
        .m0_wdat(m0_wdat), .m0_rdat(m0_rdat),
        .m1_val(m1_val), .m1_rdy(m1_rdy), .m1_adr(m1_adr), .m1_wen(m1_wen),
        .m1_wdat(m1_wdat), .m1_rdat(m1_rdat),
        .sram_en(sram_en), .sram_we(sram_we), .sram_adr(sram_adr),
        .sram_din(sram_din), .sram_dout(sram_dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic [3:0]  we;
        logic [31:0] din;
    } gnt_t;

    typedef struct {
        int          m;
        bit          rd;
        logic [31:0] data;
        time         due;
    } rsp_t;

    gnt_t gnt_q[$];
    rsp_t rsp_q[$];
    int   gnt_log[$];
    int   mon_gi = 0;
    int   mon_ri = 0;
    int   checks = 0;
    int   errors = 0;
    bit   rr_forced = 1'b0;
    bit   done0, done1;
    logic [31:0] last_rdat;

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] x;
        x = 32'(i);
        return (i == 4) ? 32'hDEADBEEF : ((x * 32'h01000193) ^ 32'hA5A5A5A5);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural SRAM: one-cycle read latency, byte-masked writes.
    initial begin
        logic [31:0] mem [256];
        logic        l_en;
        logic [3:0]  l_we;
        logic [31:0] l_adr, l_din;
        for (int i = 0; i < 256; i++) mem[i] = init_word(i);
        sram_dout = '0;
        forever begin
            @(negedge clk);
            l_en = sram_en && rst_n; l_we = sram_we; l_adr = sram_adr; l_din = sram_din;
            @(posedge clk);
            if (l_en) begin
                sram_dout <= mem[l_adr[9:2]];
                for (int b = 0; b < 4; b++)
                    if (l_we[b]) mem[l_adr[9:2]][b*8 +: 8] = l_din[b*8 +: 8];
            end
        end
    end

    // Reference model: applies the arbitration rules to the request
    // inputs each cycle and queues the expected grant and response.
    initial begin
        logic [31:0] ref_mem [256];
        bit busy;
        int last, w0, w1, win, eff_last;
        bit c0, c1;
        logic [31:0] a, d;
        logic [3:0]  w;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        busy = 0; last = 1; w0 = 0; w1 = 0;
        forever begin
            @(negedge clk); #1;
            if (!rst_n) begin
                busy = 0; last = 1; w0 = 0; w1 = 0;
            end else if (busy) begin
                busy = 0;
            end else begin
                c0 = m0_val && !i_halt;
                c1 = m1_val;
                eff_last = rr_forced ? 0 : last;
                win = -1;
                if (c0 && c1) begin
                    if (w0 >= MAXW) win = 0;
                    else if (w1 >= MAXW) win = 1;
                    else win = (eff_last == 0) ? 1 : 0;
                end else if (c0) win = 0;
                else if (c1) win = 1;
                if (win >= 0) begin
                    a = (win == 1) ? m1_adr  : m0_adr;
                    w = (win == 1) ? m1_wen  : m0_wen;
                    d = (win == 1) ? m1_wdat : m0_wdat;
                    gnt_q.push_back('{adr: a, we: w, din: d});
                    rsp_q.push_back('{m: win, rd: (w == 4'h0), data: ref_mem[a[9:2]], due: $time + 5});
                    for (int b = 0; b < 4; b++)
                        if (w[b]) ref_mem[a[9:2]][b*8 +: 8] = d[b*8 +: 8];
                    if (win == 0) begin
                        w0 = 0;
                        if (c0 && c1 && w1 < MAXW) w1++;
                    end else begin
                        w1 = 0;
                        if (c0 && c1 && w0 < MAXW) w0++;
                    end
                    last = win;
                    busy = 1;
                end
            end
        end
    end

    // Monitor: consumes expected grants when sram_en is seen and expected
    // responses when a rdy pulse is seen.
    initial begin
        bit   due;
        rsp_t e;
        forever begin
            @(negedge clk); #2;
            if (!rst_n) begin
                mon_gi = gnt_q.size();
                mon_ri = rsp_q.size();
            end else begin
                if (sram_en) begin
                    chk("grant_expected", 32'(mon_gi < gnt_q.size()), 1);
                    if (mon_gi < gnt_q.size()) begin
                        chk("grant_adr", sram_adr, gnt_q[mon_gi].adr);
                        chk("grant_we", 32'(sram_we), 32'(gnt_q[mon_gi].we));
                        chk("grant_din", sram_din, gnt_q[mon_gi].din);
                        mon_gi++;
                    end
                end else begin
                    chk("idle_we", 32'(sram_we), 0);
                end
                chk("grant_missing", 32'(gnt_q.size() - mon_gi), 0);
                mon_gi = gnt_q.size();

                chk("rdy_onehot", 32'(m0_rdy & m1_rdy), 0);
                due = (mon_ri < rsp_q.size()) && (rsp_q[mon_ri].due <= $time);
                if (m0_rdy || m1_rdy) begin
                    chk("rdy_expected", 32'(due), 1);
                    if (due) begin
                        e = rsp_q[mon_ri];
                        chk("rsp_master", 32'(m1_rdy ? 1 : 0), 32'(e.m));
                        if (e.rd) chk("rsp_rdat", (e.m == 1) ? m1_rdat : m0_rdat, e.data);
                        chk("other_rdat", (e.m == 1) ? m0_rdat : m1_rdat, 0);
                        gnt_log.push_back(m1_rdy ? 1 : 0);
                        mon_ri++;
                    end
                end else begin
                    chk("rdy_missing", 32'(due), 0);
                    if (due) mon_ri++;
                end
            end
        end
    end

    task automatic set_m(input int m, input logic v, input logic [31:0] a,
                         input logic [3:0] w, input logic [31:0] d);
        if (m == 0) begin
            m0_val = v; m0_adr = a; m0_wen = w; m0_wdat = d;
        end else begin
            m1_val = v; m1_adr = a; m1_wen = w; m1_wdat = d;
        end
    endtask

    task automatic issue(input int m, input logic [31:0] a, input logic [3:0] w,
                         input logic [31:0] d, input bit keep);
        int t;
        bit got;
        t = 0; got = 0;
        @(posedge clk); #1;
        set_m(m, 1'b1, a, w, d);
        while (t < 400) begin
            @(negedge clk);
            t++;
            if ((m == 0) ? m0_rdy : m1_rdy) begin
                last_rdat = (m == 0) ? m0_rdat : m1_rdat;
                got = 1;
                break;
            end
        end
        chk("rdy_arrived", 32'(got), 1);
        if (!keep) begin
            @(posedge clk); #1;
            set_m(m, 1'b0, a, w, d);
        end
    endtask

    task automatic drive(input int m, input int n, input bit rnd);
        int g, ng;
        logic [31:0] a, d;
        logic [3:0]  w;
        g = rnd ? $urandom_range(0, 2) : 0;
        for (int i = 0; i < n; i++) begin
            repeat (g) @(posedge clk);
            ng = rnd ? $urandom_range(0, 2) : 0;
            a = 32'($urandom_range(0, 255)) << 2;
            w = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
            d = $urandom;
            issue(m, a, w, d, (i < n - 1) && (ng == 0));
            g = ng;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int exp_alt [8];
        int exp_halt [4];
        int exp_starve [4];
        logic [31:0] w8;
        exp_halt   = '{1, 1, 1, 0};
        exp_starve = '{1, 1, 0, 1};
        for (int k = 0; k < 8; k++) exp_alt[k] = k % 2;

        rst_n = 1'b0; i_halt = 1'b0;
        set_m(0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_m(1, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m0_rdy", 32'(m0_rdy), 0);
        chk("rst_m1_rdy", 32'(m1_rdy), 0);
        chk("rst_m0_rdat", m0_rdat, 0);
        chk("rst_m1_rdat", m1_rdat, 0);
        chk("rst_sram_en", 32'(sram_en), 0);
        chk("rst_sram_we", 32'(sram_we), 0);
        chk("rst_sram_adr", sram_adr, 0);
        chk("rst_sram_din", sram_din, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // single read of preloaded word
        issue(0, 32'h10, 4'h0, 32'h0, 0);
        chk("single_read", last_rdat, 32'hDEADBEEF);

        // byte write by debug master, read back by core
        issue(1, 32'h20, 4'b0010, 32'h0000AB00, 0);
        issue(0, 32'h20, 4'h0, 32'h0, 0);
        w8 = init_word(8);
        chk("byte_write_merge", last_rdat, {w8[31:16], 8'hAB, w8[7:0]});

        // simultaneous requests alternate starting with m0 after reset
        do_reset();
        base = gnt_log.size();
        fork
            drive(0, 4, 0);
            drive(1, 4, 0);
        join
        chk("alt_count", 32'(gnt_log.size() - base), 8);
        for (int k = 0; k < 8; k++)
            if (base + k < gnt_log.size()) chk("alt_order", 32'(gnt_log[base + k]), 32'(exp_alt[k]));

        // halt lock: only m1 while halted, m0 right after release
        @(posedge clk); #1 i_halt = 1'b1;
        base = gnt_log.size();
        fork
            drive(0, 1, 0);
            begin
                drive(1, 3, 0);
                i_halt = 1'b0;
            end
        join
        chk("halt_count", 32'(gnt_log.size() - base), 4);
        for (int k = 0; k < 4; k++)
            if (base + k < gnt_log.size()) chk("halt_order", 32'(gnt_log[base + k]), 32'(exp_halt[k]));

        // starvation guard with round robin pinned toward m1
        @(posedge clk); #1;
        force dut.rr_last_q = 1'b0;
        rr_forced = 1'b1;
        base = gnt_log.size();
        fork
            drive(0, 1, 0);
            drive(1, 3, 0);
        join
        chk("starve_count", 32'(gnt_log.size() - base), 4);
        for (int k = 0; k < 4; k++)
            if (base + k < gnt_log.size()) chk("starve_order", 32'(gnt_log[base + k]), 32'(exp_starve[k]));
        release dut.rr_last_q;
        rr_forced = 1'b0;
        do_reset();

        // reset during m0's response cycle
        @(posedge clk); #1;
        set_m(0, 1'b1, 32'h10, 4'h0, 32'h0);
        @(negedge clk);
        chk("rstresp_grant", 32'(sram_en), 1);
        @(posedge clk); #1;
        set_m(0, 1'b0, 32'h10, 4'h0, 32'h0);
        chk("rstresp_rdy_before", 32'(m0_rdy), 1);
        #1 rst_n = 1'b0;
        #1 chk("rstresp_rdy_drop", 32'(m0_rdy), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rstresp_en_after", 32'(sram_en), 0);
        chk("rstresp_state", 32'(dut.state_q), 32'(IDLE));
        chk("rstresp_no_rdy", 32'(m0_rdy), 0);

        // randomized traffic with halt toggling
        done0 = 0; done1 = 0;
        fork
            begin drive(0, 40, 1); done0 = 1; end
            begin drive(1, 40, 1); done1 = 1; end
            begin
                while (!(done0 && done1)) begin
                    @(posedge clk); #1;
                    if ($urandom_range(0, 7) == 0) i_halt = ~i_halt;
                end
                i_halt = 1'b0;
            end
        join
        repeat (4) @(posedge clk);
        chk("all_grants_seen", 32'(mon_gi), 32'(gnt_q.size()));
        chk("all_rsps_seen", 32'(mon_ri), 32'(rsp_q.size()));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cirno9_sram_arb.md
Name: cirno9_sram_arb

Overview:
- Two-master arbiter in front of the single-port sram32 macro.
- Shares the SRAM between the core load/store port (m0) and the JTAG debug memory port (m1).
- Sequences each access through a grant/response FSM, covering the SRAM's one-cycle read latency.
- Applies round-robin fairness, a debug-halt lock and a starvation guard.

Parameters:
- ADDR_W, 32, address width of both masters and the SRAM.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- MAX_WAIT, 4, consecutive losses after which a waiting master is granted unconditionally.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- i_halt  in  1  debug halt; while high, only m1 is granted.
- m0_val  in  1  core request valid; held with payload until m0_rdy.
- m0_rdy  out  1  one-cycle completion pulse for m0.
- m0_adr  in  ADDR_W  core byte address.
- m0_wen  in  DATA_W/8  byte write enables; 0 means read.
- m0_wdat  in  DATA_W  core write data.
- m0_rdat  out  DATA_W  core read data, valid while m0_rdy.
- m1_val, m1_rdy, m1_adr, m1_wen, m1_wdat, m1_rdat  as m0, for the debug master.
- sram_en  out  1  SRAM access enable.
- sram_we  out  DATA_W/8  SRAM byte write enables.
- sram_adr  out  ADDR_W  SRAM address.
- sram_din  out  DATA_W  SRAM write data.
- sram_dout  in  DATA_W  SRAM read data, one cycle after sram_en.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE, owner=0, rr_last=1 (so m0 wins the first tie), both wait counters=0.
  - m0_rdy=m1_rdy=0, m0_rdat=m1_rdat=0.
  - sram_en=0, sram_we=0, sram_adr=0, sram_din=0.
- FSM states: IDLE, RESP.
- IDLE, arbitration is combinational:
  - i_halt=1: m1 is the only candidate; m0 waits and its wait counter does not count.
  - Else if exactly one val: that master wins.
  - Else if both val: a master whose wait counter equals MAX_WAIT wins; otherwise the master != rr_last wins.
- IDLE, on a grant, in the same cycle:
  - sram_en=1; sram_we/adr/din come from the winner.
  - owner<=winner, rr_last<=winner, state<=RESP.
  - Loser's wait counter increments, saturating at MAX_WAIT; winner's counter clears.
- IDLE with no val: sram_en=0, sram_we=0; sram_adr and sram_din hold their last value; state holds.
- RESP:
  - owner's rdy=1 and owner's rdat=sram_dout (combinational); the other master's rdy=0 and rdat=0.
  - state<=IDLE.
  - sram_en=0; no new grant this cycle.
- Latency: val high in cycle N with immediate grant gives rdy in N+1. Throughput is one access per 2 cycles.
- Writes complete the same way with rdy in N+1; rdat content for writes is unspecified.
- A master never sees rdy while another master owns the SRAM. rdy never asserts without a prior grant.
- Val dropped mid-transaction (protocol violation): the access still completes and rdy still pulses.
- i_halt changes while in RESP: no effect on the in-flight transaction; it applies at the next IDLE arbitration.
- Asynchronous reset mid-RESP: rdy drops immediately; the in-flight transaction is discarded and not replayed.
- Wait counters are ceil(log2(MAX_WAIT+1)) bits wide and saturate; no wrap.

Decomposition:
- Package cirno9_sram_arb_pkg holds:
  - the state enum {IDLE, RESP};
  - the master index constants M_CORE=0 and M_DBG=1;
  - a helper function for the wait-counter width.
- Sub-module cirno9_rr_pick2: combinational 2-way winner select from {val0, val1, rr_last, starve0, starve1, halt}.
- The FSM, counters and muxing stay in the top module.

Test Plan:
- Single read: preload sram[0x10]=0xDEADBEEF; m0 read 0x10 at cycle N -> sram_en=1 at N; m0_rdy=1 with m0_rdat=0xDEADBEEF at N+1; m1_rdy=0.
- Byte write: m1 write adr 0x20, wen=4'b0010, wdat=0x0000AB00 -> sram_we=4'b0010 during grant; a later m0 read of 0x20 shows byte1=0xAB and the other bytes unchanged.
- Simultaneous requests: both val held continuously for 8 accesses -> grants alternate m0, m1, m0, m1..., starting with m0 after reset.
- Halt lock: i_halt=1, both val -> m1 granted every 2 cycles; m0_rdy stays 0; after i_halt=0, m0 is granted at the next IDLE.
- Reset in RESP: assert rst_n=0 during m0's RESP cycle -> m0_rdy=0 immediately; after release, state=IDLE and sram_en=0.
- Starvation guard: MAX_WAIT=2; force rr_last toward m1 via a test hook while both val -> m0 is granted by its second consecutive loss.
